// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised single-issue CPU core.
// Fetches 32-bit instructions combinationally from a flat code bus.
// Features a registered valid/ready output port with back-pressure stall,
// a restoring multi-cycle divider with sticky divide-by-zero flag, and HALT.
module cpu_core_p #(
  parameter int REG_W = 8,
  parameter int NREGS = 8,
  parameter int PC_W  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [(32<<PC_W)-1:0]     code,
  output logic [REG_W-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      halted,
  output logic                      div0
);

  localparam int RA_W  = $clog2(NREGS);
  localparam int CNT_W = $clog2(REG_W);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [1:0] CMP_LT = 2'd0;
  localparam logic [1:0] CMP_EQ = 2'd1;
  localparam logic [1:0] CMP_GT = 2'd2;

  localparam logic [4:0] OP_IMM  = 5'd1;
  localparam logic [4:0] OP_OUT  = 5'd2;
  localparam logic [4:0] OP_JMP  = 5'd3;
  localparam logic [4:0] OP_IJMP = 5'd4;
  localparam logic [4:0] OP_JLT  = 5'd5;
  localparam logic [4:0] OP_JEQ  = 5'd6;
  localparam logic [4:0] OP_JGT  = 5'd7;
  localparam logic [4:0] OP_INC  = 5'd8;
  localparam logic [4:0] OP_DEC  = 5'd9;
  localparam logic [4:0] OP_ADD  = 5'd10;
  localparam logic [4:0] OP_SUB  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd12;
  localparam logic [4:0] OP_DIV  = 5'd13;
  localparam logic [4:0] OP_AND  = 5'd14;
  localparam logic [4:0] OP_OR   = 5'd15;
  localparam logic [4:0] OP_XOR  = 5'd16;
  localparam logic [4:0] OP_CMP  = 5'd17;
  localparam logic [4:0] OP_HALT = 5'd18;

  // Architectural state
  logic [PC_W-1:0]  r_pc;
  logic [REG_W-1:0] r_regs [NREGS];
  logic [1:0]       r_cmp;
  logic [1:0]       r_state;
  logic [REG_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_halted;
  logic             r_div0;

  // Divider working state
  logic [REG_W-1:0] r_dq;
  logic [REG_W-1:0] r_dvs;
  logic [REG_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [RA_W-1:0]  r_dst;

  // Decode
  logic [31:0]           w_instr;
  logic [4:0]            w_op;
  logic [RA_W-1:0]       w_ra_idx;
  logic [RA_W-1:0]       w_rb_idx;
  logic [REG_W-1:0]      w_ra;
  logic [REG_W-1:0]      w_rb;
  logic [REG_W+15:0]     w_imm_ext;
  logic [REG_W-1:0]      w_imm;
  logic [PC_W-1:0]       w_imm_pc;
  logic [REG_W+PC_W-1:0] w_ra_ext;
  logic [PC_W-1:0]       w_ra_pc;
  logic [PC_W-1:0]       w_pc_inc;
  logic [1:0]            w_cmp_res;
  logic                  w_stall;

  assign w_instr   = code[{r_pc, 5'b00000} +: 32];
  assign w_op      = w_instr[31:27];
  assign w_ra_idx  = w_instr[23 +: RA_W];
  assign w_rb_idx  = w_instr[19 +: RA_W];
  assign w_ra      = r_regs[w_ra_idx];
  assign w_rb      = r_regs[w_rb_idx];
  assign w_imm_ext = {{REG_W{1'b0}}, w_instr[15:0]};
  assign w_imm     = w_imm_ext[REG_W-1:0];
  assign w_imm_pc  = w_instr[PC_W-1:0];
  assign w_ra_ext  = {{PC_W{1'b0}}, w_ra};
  assign w_ra_pc   = w_ra_ext[PC_W-1:0];
  assign w_pc_inc  = r_pc + 1'b1;
  assign w_cmp_res = (w_ra < w_rb) ? CMP_LT : ((w_ra == w_rb) ? CMP_EQ : CMP_GT);
  assign w_stall   = r_out_valid && !out_ready;

  // Divider datapath: one restoring shift-subtract step
  logic [REG_W:0]   w_rem_sh;
  logic [REG_W:0]   w_sub;
  logic             w_qbit;
  logic [REG_W-1:0] w_rem_nxt;
  logic [REG_W-1:0] w_dq_nxt;
  logic             w_div_last;

  assign w_rem_sh   = {r_rem, r_dq[REG_W-1]};
  assign w_sub      = w_rem_sh - {1'b0, r_dvs};
  assign w_qbit     = !w_sub[REG_W];
  assign w_rem_nxt  = w_qbit ? w_sub[REG_W-1:0] : w_rem_sh[REG_W-1:0];
  assign w_dq_nxt   = {r_dq[REG_W-2:0], w_qbit};
  assign w_div_last = (r_cnt == CNT_W'(REG_W - 1));

  logic w_unused;
  assign w_unused = ^{w_instr, w_imm_ext, w_ra_ext, w_rem_sh};

  // Next-state control
  logic [PC_W-1:0]  w_pc_nxt;
  logic [1:0]       w_state_nxt;
  logic [1:0]       w_cmp_nxt;
  logic             w_we;
  logic [RA_W-1:0]  w_wsel;
  logic [REG_W-1:0] w_wd;
  logic             w_out_load;
  logic             w_div_start;
  logic             w_div0_set;
  logic             w_halt_set;

  // Instruction execution and state transitions
  always_comb begin
    w_pc_nxt    = r_pc;
    w_state_nxt = r_state;
    w_cmp_nxt   = r_cmp;
    w_we        = 1'b0;
    w_wsel      = w_ra_idx;
    w_wd        = '0;
    w_out_load  = 1'b0;
    w_div_start = 1'b0;
    w_div0_set  = 1'b0;
    w_halt_set  = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_pc_nxt = w_pc_inc;
        case (w_op)
          OP_IMM: begin w_we = 1'b1; w_wd = w_imm; end
          OP_OUT: begin
            if (w_stall) w_pc_nxt = r_pc;
            else         w_out_load = 1'b1;
          end
          OP_JMP:  w_pc_nxt = w_imm_pc;
          OP_IJMP: w_pc_nxt = w_ra_pc;
          OP_JLT:  if (r_cmp == CMP_LT) w_pc_nxt = w_imm_pc;
          OP_JEQ:  if (r_cmp == CMP_EQ) w_pc_nxt = w_imm_pc;
          OP_JGT:  if (r_cmp == CMP_GT) w_pc_nxt = w_imm_pc;
          OP_INC:  begin w_we = 1'b1; w_wd = w_ra + 1'b1; end
          OP_DEC:  begin w_we = 1'b1; w_wd = w_ra - 1'b1; end
          OP_ADD:  begin w_we = 1'b1; w_wd = w_ra + w_rb; end
          OP_SUB:  begin w_we = 1'b1; w_wd = w_ra - w_rb; w_cmp_nxt = w_cmp_res; end
          OP_MUL:  begin w_we = 1'b1; w_wd = w_ra * w_rb; end
          OP_AND:  begin w_we = 1'b1; w_wd = w_ra & w_rb; end
          OP_OR:   begin w_we = 1'b1; w_wd = w_ra | w_rb; end
          OP_XOR:  begin w_we = 1'b1; w_wd = w_ra ^ w_rb; end
          OP_CMP:  w_cmp_nxt = w_cmp_res;
          OP_DIV: begin
            if (w_rb == '0) begin
              w_we       = 1'b1;
              w_wd       = '1;
              w_div0_set = 1'b1;
            end else begin
              w_div_start = 1'b1;
              w_pc_nxt    = r_pc;
              w_state_nxt = ST_DIV;
            end
          end
          OP_HALT: begin
            w_halt_set  = 1'b1;
            w_pc_nxt    = r_pc;
            w_state_nxt = ST_HALT;
          end
          default: ;
        endcase
      end
      ST_DIV: begin
        if (w_div_last) begin
          w_we        = 1'b1;
          w_wsel      = r_dst;
          w_wd        = w_dq_nxt;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = ST_RUN;
        end
      end
      default: ;
    endcase
  end

  // State registers, register file, output port and divider
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= '0;
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_cmp       <= CMP_EQ;
      r_state     <= ST_RUN;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      r_div0      <= 1'b0;
      r_dq        <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_dst       <= '0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
      r_cmp   <= w_cmp_nxt;
      if (w_we) r_regs[w_wsel] <= w_wd;
      // A new OUT overrides the consume-clear so accept-and-reload keeps valid high
      if (w_out_load) begin
        r_out_data  <= w_ra;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_halt_set) r_halted <= 1'b1;
      if (w_div0_set) r_div0   <= 1'b1;
      if (w_div_start) begin
        r_dq  <= w_ra;
        r_dvs <= w_rb;
        r_rem <= '0;
        r_cnt <= '0;
        r_dst <= w_ra_idx;
      end else if (r_state == ST_DIV) begin
        r_dq  <= w_dq_nxt;
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign halted    = r_halted;
  assign div0      = r_div0;

endmodule

// File: tb/tb_cpu_core_p.sv
// Directed testbench for cpu_core_p with default parameters.
module tb_cpu_core_p;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] code = '0;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         halted;
  logic         div0;

  int total = 0;
  int bad   = 0;
  logic [31:0] prog [8];

  cpu_core_p #(.REG_W(8), .NREGS(8), .PC_W(3)) dut (
    .clk(clk), .reset(reset), .code(code), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .halted(halted), .div0(div0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input int op, input int ra, input int rb, input int imm);
    return {op[4:0], ra[3:0], rb[3:0], 3'b000, imm[15:0]};
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 8; i++) prog[i] = 32'h0;
  endtask

  // Load program and apply a two-cycle reset; next edge fetches word 0
  task automatic boot();
    for (int i = 0; i < 8; i++) code[32*i +: 32] = prog[i];
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    // 1: SUB then OUT then HALT
    clr();
    prog[0] = ins(1, 0, 0, 5);
    prog[1] = ins(1, 1, 0, 3);
    prog[2] = ins(11, 0, 1, 0);
    prog[3] = ins(2, 0, 0, 0);
    prog[4] = ins(18, 0, 0, 0);
    out_ready = 1'b1;
    boot();
    chk("rst_out_data", {24'h0, out_data}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_div0", {31'h0, div0}, 32'h0);
    chk("rst_pc", {29'h0, dut.r_pc}, 32'h0);
    tick(4);
    chk("t1_out_data", {24'h0, out_data}, 32'h2);
    chk("t1_out_valid", {31'h0, out_valid}, 32'h1);
    tick(1);
    chk("t1_halted", {31'h0, halted}, 32'h1);
    chk("t1_pc_halt", {29'h0, dut.r_pc}, 32'h4);
    chk("t1_valid_consumed", {31'h0, out_valid}, 32'h0);
    tick(2);
    chk("t1_pc_frozen", {29'h0, dut.r_pc}, 32'h4);

    // 2: back-pressure stall on second OUT
    clr();
    prog[0] = ins(1, 0, 0, 7);
    prog[1] = ins(2, 0, 0, 0);
    prog[2] = ins(1, 0, 0, 9);
    prog[3] = ins(2, 0, 0, 0);
    prog[4] = ins(18, 0, 0, 0);
    out_ready = 1'b0;
    boot();
    tick(5);
    chk("t2_stall_pc", {29'h0, dut.r_pc}, 32'h3);
    chk("t2_stall_data", {24'h0, out_data}, 32'h7);
    chk("t2_stall_valid", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1;
    tick(1);
    chk("t2_reload_data", {24'h0, out_data}, 32'h9);
    chk("t2_reload_valid", {31'h0, out_valid}, 32'h1);
    chk("t2_pc_once", {29'h0, dut.r_pc}, 32'h4);
    tick(1);
    chk("t2_pc_halt", {29'h0, dut.r_pc}, 32'h4);
    chk("t2_valid_clear", {31'h0, out_valid}, 32'h0);

    // 3a: 200/7 takes issue + 8 cycles
    clr();
    prog[0] = ins(1, 0, 0, 200);
    prog[1] = ins(1, 1, 0, 7);
    prog[2] = ins(13, 0, 1, 0);
    prog[3] = ins(2, 0, 0, 0);
    prog[4] = ins(18, 0, 0, 0);
    out_ready = 1'b1;
    boot();
    tick(10);
    chk("t3_div_busy_pc", {29'h0, dut.r_pc}, 32'h2);
    chk("t3_div_busy_r0", {24'h0, dut.r_regs[0]}, 32'd200);
    tick(1);
    chk("t3_div_done_pc", {29'h0, dut.r_pc}, 32'h3);
    chk("t3_div_quot", {24'h0, dut.r_regs[0]}, 32'd28);
    tick(1);
    chk("t3_div_out", {24'h0, out_data}, 32'd28);
    chk("t3_div0_clear", {31'h0, div0}, 32'h0);

    // 3b: divide by zero in one cycle
    clr();
    prog[0] = ins(1, 0, 0, 200);
    prog[1] = ins(13, 0, 1, 0);
    prog[2] = ins(2, 0, 0, 0);
    prog[3] = ins(18, 0, 0, 0);
    boot();
    tick(2);
    chk("t3_dz_r0", {24'h0, dut.r_regs[0]}, 32'hFF);
    chk("t3_dz_div0", {31'h0, div0}, 32'h1);
    chk("t3_dz_pc", {29'h0, dut.r_pc}, 32'h2);
    tick(3);
    chk("t3_dz_out", {24'h0, out_data}, 32'hFF);
    chk("t3_dz_sticky", {31'h0, div0}, 32'h1);

    // 4a: CMP/JLT loop counting to 3
    clr();
    prog[0] = ins(1, 0, 0, 0);
    prog[1] = ins(1, 1, 0, 3);
    prog[2] = ins(8, 0, 0, 0);
    prog[3] = ins(17, 0, 1, 0);
    prog[4] = ins(5, 0, 0, 2);
    prog[5] = ins(2, 0, 0, 0);
    prog[6] = ins(18, 0, 0, 0);
    boot();
    tick(5);
    chk("t4_loop_back", {29'h0, dut.r_pc}, 32'h2);
    tick(6);
    chk("t4_loop_exit", {29'h0, dut.r_pc}, 32'h5);
    tick(1);
    chk("t4_loop_out", {24'h0, out_data}, 32'h3);

    // 4b: ALU ops with wrap; OUT at word 7 wraps pc to 0
    clr();
    prog[0] = ins(1, 0, 0, 250);
    prog[1] = ins(10, 0, 0, 0);
    prog[2] = ins(1, 1, 0, 16'h0F);
    prog[3] = ins(16, 1, 0, 0);
    prog[4] = ins(12, 1, 1, 0);
    prog[5] = ins(15, 1, 0, 0);
    prog[6] = ins(14, 1, 0, 0);
    prog[7] = ins(2, 1, 0, 0);
    boot();
    tick(2);
    chk("t4_add_wrap", {24'h0, dut.r_regs[0]}, 32'd244);
    tick(2);
    chk("t4_xor", {24'h0, dut.r_regs[1]}, 32'hFB);
    tick(1);
    chk("t4_mul", {24'h0, dut.r_regs[1]}, 32'h19);
    tick(1);
    chk("t4_or", {24'h0, dut.r_regs[1]}, 32'hFD);
    tick(2);
    chk("t4_and_out", {24'h0, out_data}, 32'hF4);
    chk("t4_out_wrap_pc", {29'h0, dut.r_pc}, 32'h0);

    // 5: JMP 7 then wrap, JEQ both ways, IJMP truncation, DEC
    clr();
    prog[0] = ins(6, 0, 0, 2);
    prog[1] = ins(4, 2, 0, 0);
    prog[2] = ins(1, 2, 0, 16'h0D);
    prog[3] = ins(17, 2, 3, 0);
    prog[4] = ins(3, 0, 0, 7);
    prog[5] = ins(9, 2, 0, 0);
    prog[6] = ins(18, 0, 0, 0);
    prog[7] = ins(0, 0, 0, 0);
    boot();
    tick(1);
    chk("t5_jeq_taken", {29'h0, dut.r_pc}, 32'h2);
    tick(3);
    chk("t5_jmp7", {29'h0, dut.r_pc}, 32'h7);
    tick(1);
    chk("t5_pc_wrap", {29'h0, dut.r_pc}, 32'h0);
    tick(1);
    chk("t5_jeq_fall", {29'h0, dut.r_pc}, 32'h1);
    tick(1);
    chk("t5_ijmp", {29'h0, dut.r_pc}, 32'h5);
    tick(2);
    chk("t5_dec", {24'h0, dut.r_regs[2]}, 32'h0C);
    chk("t5_halted", {31'h0, halted}, 32'h1);

    // 6: reset during the 4th cycle of a DIV
    clr();
    prog[0] = ins(13, 0, 1, 0);
    prog[1] = ins(1, 1, 0, 7);
    prog[2] = ins(2, 0, 0, 0);
    prog[3] = ins(13, 0, 1, 0);
    out_ready = 1'b0;
    boot();
    tick(6);
    chk("t6_pre_pc", {29'h0, dut.r_pc}, 32'h3);
    chk("t6_pre_div0", {31'h0, div0}, 32'h1);
    chk("t6_pre_valid", {31'h0, out_valid}, 32'h1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t6_rst_pc", {29'h0, dut.r_pc}, 32'h0);
    chk("t6_rst_r0", {24'h0, dut.r_regs[0]}, 32'h0);
    chk("t6_rst_r1", {24'h0, dut.r_regs[1]}, 32'h0);
    chk("t6_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("t6_rst_data", {24'h0, out_data}, 32'h0);
    chk("t6_rst_div0", {31'h0, div0}, 32'h0);
    tick(1);
    chk("t6_run_again_pc", {29'h0, dut.r_pc}, 32'h1);
    chk("t6_run_again_div0", {31'h0, div0}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
